// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data-memory responder
// Purpose: FSM state encoding, latency counter width and index-width helper.
// Ports: none (package).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int LAT_W = 4;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x 32 storage, synchronous write, combinational read
// Purpose: word storage behind the responder; contents are never reset.
// Ports:
//   clk_i     in   clock
//   we_i      in   write enable, commits at rising edge
//   waddr_i   in   write word index
//   wdata_i   in   write data
//   raddr_i   in   read word index
//   rdata_o   out  read data (combinational)
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder for the MEM stage
// Purpose: services MemRead/MemWrite after LATENCY cycles, holding stall_o
//   while a request is outstanding. Optional macro DMEM_WRITE_BUFFER_EN adds
//   a one-entry posted write buffer.
// Ports:
//   clk_i       in   clock
//   rst_i       in   asynchronous active-low reset
//   MemRead_i   in   read request (level)
//   MemWrite_i  in   write request (level)
//   addr_i      in   byte address
//   data_i      in   write data
//   data_o      out  read data, valid while valid_o
//   valid_o     out  one-cycle read completion pulse
//   stall_o     out  pipeline hold request
//   err_o       out  one-cycle misaligned/conflict pulse
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int IDX_W = clog2(DEPTH);
  localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LATENCY - 1);
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               bad_q, bad_d;
  logic               misal_q, misal_d;
  logic [31:0]        data_q, data_d;

  logic               req, misaligned, conflict, accept, stall;
  logic               valid, err, fsm_we;
  logic [31:0]        data_out, rd_data;
  logic [IDX_W-1:0]   addr_idx;

  logic               arr_we;
  logic [IDX_W-1:0]   arr_waddr;
  logic [31:0]        arr_wdata;

  logic               unused_addr;

`ifdef DMEM_WRITE_BUFFER_EN
  localparam logic [LAT_W-1:0] LAT_FULL = LAT_W'(LATENCY);
  logic               wb_valid_q, wb_valid_d;
  logic [IDX_W-1:0]   wb_idx_q, wb_idx_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [LAT_W-1:0]   wb_cnt_q, wb_cnt_d;
  logic               wb_commit;
`endif

  assign req        = MemRead_i | MemWrite_i;
  assign misaligned = (addr_i[1:0] != 2'b00);
  assign conflict   = MemRead_i & MemWrite_i;
  assign addr_idx   = addr_i[IDX_W+1:2];
  // Bits above the index are ignored, so addresses wrap modulo DEPTH*4.
  assign unused_addr = ^addr_i[31:IDX_W+2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    bad_d    = bad_q;
    misal_d  = misal_q;
    accept   = 1'b0;
    stall    = 1'b0;
    valid    = 1'b0;
    err      = 1'b0;
    fsm_we   = 1'b0;
    data_out = data_q;
`ifdef DMEM_WRITE_BUFFER_EN
    wb_valid_d = wb_valid_q;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;
    wb_cnt_d   = wb_cnt_q;
    wb_commit  = 1'b0;
    if (wb_valid_q) begin
      wb_cnt_d = wb_cnt_q - LAT_ONE;
      if (wb_cnt_q == LAT_ONE) begin
        wb_commit  = 1'b1;
        wb_valid_d = 1'b0;
      end
    end
`endif

    unique case (state_q)
      IDLE: begin
        accept = req;
`ifdef DMEM_WRITE_BUFFER_EN
        // Any write waits for an empty buffer, so the blocking write path and
        // the buffer commit never contend for the array write port.
        if (MemWrite_i && wb_valid_q) begin
          accept = 1'b0;
          stall  = 1'b1;
        end else if (MemWrite_i && !MemRead_i && !misaligned) begin
          accept     = 1'b0;
          wb_valid_d = 1'b1;
          wb_idx_d   = addr_idx;
          wb_data_d  = data_i;
          wb_cnt_d   = LAT_FULL;
        end
`endif
        if (accept) begin
          stall   = 1'b1;
          wr_d    = MemWrite_i;
          idx_d   = addr_idx;
          wdata_d = data_i;
          misal_d = misaligned;
          bad_d   = misaligned | conflict;
          cnt_d   = LAT_M1;
          state_d = (misaligned || LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - LAT_ONE;
        if (cnt_q == LAT_ONE) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        err     = bad_q;
        if (misal_q) begin
          data_out = '0;
        end else if (wr_q) begin
          fsm_we = 1'b1;
        end else begin
          valid    = 1'b1;
          data_out = rd_data;
`ifdef DMEM_WRITE_BUFFER_EN
          if (wb_valid_q && wb_idx_q == idx_q) data_out = wb_data_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    data_d = data_out;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      bad_q      <= 1'b0;
      misal_q    <= 1'b0;
      data_q     <= '0;
`ifdef DMEM_WRITE_BUFFER_EN
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      wb_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      bad_q      <= bad_d;
      misal_q    <= misal_d;
      data_q     <= data_d;
`ifdef DMEM_WRITE_BUFFER_EN
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      wb_cnt_q   <= wb_cnt_d;
`endif
    end
  end

`ifdef DMEM_WRITE_BUFFER_EN
  assign arr_we    = fsm_we | wb_commit;
  assign arr_waddr = wb_commit ? wb_idx_q : idx_q;
  assign arr_wdata = wb_commit ? wb_data_q : wdata_q;
`else
  assign arr_we    = fsm_we;
  assign arr_waddr = idx_q;
  assign arr_wdata = wdata_q;
`endif

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .raddr_i (idx_q),
    .rdata_o (rd_data)
  );

  // Gated by reset so a request held across reset does not keep the pipe frozen.
  assign stall_o = rst_i & stall;
  assign valid_o = valid;
  assign err_o   = err;
  assign data_o  = data_out;

endmodule
